palette_stage: RTL and testbench

Converts the 8-bit palette-indexed or 16-bit direct pixel stream from the bitplane-to-raster stage into 8-bit-per-channel RGB plus 4-bit alpha for the video output mixer. It holds a 256-entry × 16-bit ARGB4444 palette in an on-chip dual-port RAM, which the host loads one byte at a time. After reset, a clear engine zeroes the whole palette before lookups are allowed.

---
 rtl/gpu_video_pkg.sv | 39 +++
 rtl/palette_stage_if.sv | 38 +++
 rtl/palette_ram.sv | 23 ++
 rtl/palette_stage.sv | 144 ++++++++++++++
 tb/tb_palette_stage.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_video_pkg.sv
// Shared video-pipeline types: colour field positions,
// palette depth and the palette clear-engine states.
package gpu_video_pkg;

  localparam int PAL_DEPTH = 256;

  // ARGB4444 palette word
  localparam int A4_HI = 15;
  localparam int A4_LO = 12;
  localparam int R4_HI = 11;
  localparam int R4_LO = 8;
  localparam int G4_HI = 7;
  localparam int G4_LO = 4;
  localparam int B4_HI = 3;
  localparam int B4_LO = 0;

  // RGB565 direct pixel
  localparam int R5_HI = 15;
  localparam int R5_LO = 11;
  localparam int G6_HI = 10;
  localparam int G6_LO = 5;
  localparam int B5_HI = 4;
  localparam int B5_LO = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic       mode;
    logic [7:0] h;
    logic [7:0] l;
    logic       ena;
    logic       en;
    logic [9:0] x;
  } pix_t;

endpackage

// File: rtl/palette_stage_if.sv
// Pixel stream, host palette port and colour outputs
// of the palette stage.
interface palette_stage_if;
  logic [3:0] pc_ena;
  logic       pixel_in_ena;
  logic       enable_in;
  logic       mode_16bit;
  logic [7:0] pixel_in;
  logic [7:0] pixel_in_h;
  logic [9:0] x_in;
  logic       pal_wr_ena;
  logic [8:0] pal_wr_addr;
  logic [7:0] pal_wr_data;
  logic       pal_busy;
  logic [7:0] r_out;
  logic [7:0] g_out;
  logic [7:0] b_out;
  logic [3:0] a_out;
  logic       pixel_out_ena;
  logic       enable_out;
  logic [9:0] x_out;

  modport master (
    output pc_ena, pixel_in_ena, enable_in, mode_16bit,
    output pixel_in, pixel_in_h, x_in,
    output pal_wr_ena, pal_wr_addr, pal_wr_data,
    input  pal_busy, r_out, g_out, b_out, a_out,
    input  pixel_out_ena, enable_out, x_out
  );

  modport slave (
    input  pc_ena, pixel_in_ena, enable_in, mode_16bit,
    input  pixel_in, pixel_in_h, x_in,
    input  pal_wr_ena, pal_wr_addr, pal_wr_data,
    output pal_busy, r_out, g_out, b_out, a_out,
    output pixel_out_ena, enable_out, x_out
  );
endinterface

// File: rtl/palette_ram.sv
// Simple dual-port palette RAM, synchronous read,
// read-before-write on address collision.
module palette_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/palette_stage.sv
// Palette lookup / RGB565 expansion stage with host
// byte-wide palette loading and a post-reset clear engine.
module palette_stage
  import gpu_video_pkg::*;
#(
  parameter int PAL_BITS = 8
) (
  input logic           clk,
  input logic           reset,
  palette_stage_if.slave bus
);

  clr_state_e          state_q, state_d;
  logic [PAL_BITS:0]   cnt_q, cnt_d;
  logic [7:0]          lo_q, lo_d;
  logic                ram_we;
  logic [PAL_BITS-1:0] ram_waddr;
  logic [15:0]         ram_wdata;
  logic [15:0]         ram_rdata;
  logic                tick;
  logic                busy;
  pix_t                sa_q, sa_d;
  logic [15:0]         p;
  logic [7:0]          r_q, g_q, b_q, r_d, g_d, b_d;
  logic [3:0]          a_q, a_d;
  logic                pe_q, en_q;
  logic [9:0]          x_q;

  assign tick = (bus.pc_ena == 4'd0);
  assign busy = (state_q == CLEAR);

  // Clear engine owns the write port until it finishes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q[PAL_BITS]) begin
          state_d = RUN;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = cnt_q[PAL_BITS-1:0];
          cnt_d     = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.pal_wr_ena) begin
          if (bus.pal_wr_addr[0]) begin
            ram_we    = 1'b1;
            ram_waddr = bus.pal_wr_addr[PAL_BITS:1];
            ram_wdata = {bus.pal_wr_data, lo_q};
          end else begin
            lo_d = bus.pal_wr_data;
          end
        end
      end
    endcase
  end

  palette_ram #(.AW(PAL_BITS), .DW(16)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (tick),
    .raddr_i (bus.pixel_in[PAL_BITS-1:0]),
    .rdata_o (ram_rdata)
  );

  assign sa_d = '{
    mode: bus.mode_16bit,
    h:    bus.pixel_in_h,
    l:    bus.pixel_in,
    ena:  bus.pixel_in_ena,
    en:   bus.enable_in,
    x:    bus.x_in
  };

  assign p = {sa_q.h, sa_q.l};

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    a_d = '0;
    if (sa_q.ena && sa_q.en && !busy) begin
      if (sa_q.mode) begin
        r_d = {p[R5_HI:R5_LO], p[R5_HI -: 3]};
        g_d = {p[G6_HI:G6_LO], p[G6_HI -: 2]};
        b_d = {p[B5_HI:B5_LO], p[B5_HI -: 3]};
        a_d = 4'hF;
      end else begin
        a_d = ram_rdata[A4_HI:A4_LO];
        r_d = {2{ram_rdata[R4_HI:R4_LO]}};
        g_d = {2{ram_rdata[G4_HI:G4_LO]}};
        b_d = {2{ram_rdata[B4_HI:B4_LO]}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      lo_q    <= '0;
      sa_q    <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      a_q     <= '0;
      pe_q    <= 1'b0;
      en_q    <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      if (tick) begin
        sa_q <= sa_d;
        r_q  <= r_d;
        g_q  <= g_d;
        b_q  <= b_d;
        a_q  <= a_d;
        pe_q <= sa_q.ena;
        en_q <= sa_q.en;
        x_q  <= sa_q.x;
      end
    end
  end

  assign bus.pal_busy      = busy;
  assign bus.r_out         = r_q;
  assign bus.g_out         = g_q;
  assign bus.b_out         = b_q;
  assign bus.a_out         = a_q;
  assign bus.pixel_out_ena = pe_q;
  assign bus.enable_out    = en_q;
  assign bus.x_out         = x_q;

endmodule

// File: tb/tb_palette_stage.sv
// Directed bench for palette_stage with a cycle-level
// behavioural model compared on every negative edge.
module tb_palette_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   phase;
  bit   armed;

  palette_stage_if bus();

  palette_stage #(.PAL_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_since;
  int          m_lo;
  logic [15:0] pal_m [256];
  int          sa_mode, sa_h, sa_l, sa_ena, sa_en, sa_x, sa_q;
  int          e_r, e_g, e_b, e_a, e_pe, e_en, e_x;

  always @(posedge clk) begin
    int  pw, r5, g6, b5;
    bit  mb;
    if (reset) begin
      m_since = 0;
      m_lo    = 0;
      sa_mode = 0; sa_h = 0; sa_l = 0;
      sa_ena = 0; sa_en = 0; sa_x = 0; sa_q = 0;
      e_r = 0; e_g = 0; e_b = 0; e_a = 0;
      e_pe = 0; e_en = 0; e_x = 0;
      for (int i = 0; i < 256; i++) pal_m[i] = 16'h0;
    end else begin
      mb = (m_since < 257);
      if (bus.pc_ena == 4'd0) begin
        e_pe = sa_ena;
        e_en = sa_en;
        e_x  = sa_x;
        if (sa_ena == 0 || sa_en == 0 || mb) begin
          e_r = 0; e_g = 0; e_b = 0; e_a = 0;
        end else if (sa_mode != 0) begin
          pw  = sa_h * 256 + sa_l;
          r5  = (pw / 2048) % 32;
          g6  = (pw / 32) % 64;
          b5  = pw % 32;
          e_r = r5 * 8 + r5 / 4;
          e_g = g6 * 4 + g6 / 16;
          e_b = b5 * 8 + b5 / 4;
          e_a = 15;
        end else begin
          e_a = sa_q / 4096;
          e_r = ((sa_q / 256) % 16) * 17;
          e_g = ((sa_q / 16) % 16) * 17;
          e_b = (sa_q % 16) * 17;
        end
        sa_mode = int'(bus.mode_16bit);
        sa_h    = int'(bus.pixel_in_h);
        sa_l    = int'(bus.pixel_in);
        sa_ena  = int'(bus.pixel_in_ena);
        sa_en   = int'(bus.enable_in);
        sa_x    = int'(bus.x_in);
        sa_q    = int'(pal_m[bus.pixel_in]);
      end
      if (!mb && bus.pal_wr_ena) begin
        if (bus.pal_wr_addr[0])
          pal_m[bus.pal_wr_addr[8:1]] = {bus.pal_wr_data, 8'(m_lo)};
        else
          m_lo = int'(bus.pal_wr_data);
      end
      if (m_since < 1000) m_since++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(bus.pal_busy), 32'(m_since < 257));
      chk("r", 32'(bus.r_out), e_r);
      chk("g", 32'(bus.g_out), e_g);
      chk("b", 32'(bus.b_out), e_b);
      chk("a", 32'(bus.a_out), e_a);
      chk("pe", 32'(bus.pixel_out_ena), e_pe);
      chk("en", 32'(bus.enable_out), e_en);
      chk("x", 32'(bus.x_out), e_x);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clk1();
    @(negedge clk);
    bus.pal_wr_ena = 1'b0;
    phase++;
    bus.pc_ena = 4'(phase % 4);
  endtask

  task automatic set_pix(bit m, logic [7:0] h, logic [7:0] l,
                         bit ena, bit en, logic [9:0] x);
    bus.mode_16bit   = m;
    bus.pixel_in_h   = h;
    bus.pixel_in     = l;
    bus.pixel_in_ena = ena;
    bus.enable_in    = en;
    bus.x_in         = x;
  endtask

  task automatic send_pix(bit m, logic [7:0] h, logic [7:0] l,
                          bit ena, bit en, logic [9:0] x);
    for (int k = 0; k < 4; k++) begin
      clk1();
      if (bus.pc_ena == 4'd0) break;
    end
    set_pix(m, h, l, ena, en, x);
  endtask

  task automatic host_wr(logic [8:0] addr, logic [7:0] data);
    bus.pal_wr_addr = addr;
    bus.pal_wr_data = data;
    bus.pal_wr_ena  = 1'b1;
    clk1();
  endtask

  task automatic look(bit m, logic [7:0] h, logic [7:0] l);
    send_pix(m, h, l, 1'b1, 1'b1, 10'd5);
    send_pix(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 10'd0);
    clk1();
  endtask

  task automatic chk4(string nm, int r, int g, int b, int a);
    chk({nm, "_r"}, 32'(bus.r_out), r);
    chk({nm, "_g"}, 32'(bus.g_out), g);
    chk({nm, "_b"}, 32'(bus.b_out), b);
    chk({nm, "_a"}, 32'(bus.a_out), a);
  endtask

  task automatic count_busy(output int n);
    bit done;
    n    = 0;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      clk1();
      if (bus.pal_busy) n++;
      else done = 1;
      if (i == 20) chk("clr_mask_r", 32'(bus.r_out), 0);
      if (i == 50) begin
        bus.pal_wr_addr = 9'h006;
        bus.pal_wr_data = 8'h12;
        bus.pal_wr_ena  = 1'b1;
      end
      if (i == 54) begin
        bus.pal_wr_addr = 9'h007;
        bus.pal_wr_data = 8'h34;
        bus.pal_wr_ena  = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    phase  = 0;
    armed  = 0;
    reset  = 1'b1;
    bus.pc_ena      = 4'd0;
    bus.pal_wr_ena  = 1'b0;
    bus.pal_wr_addr = '0;
    bus.pal_wr_data = '0;
    set_pix(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 10'd0);
    clk1();
    armed = 1;
    clk1();
    clk1();
    chk("rst_busy", 32'(bus.pal_busy), 1);
    chk("rst_x", 32'(bus.x_out), 0);

    // clear with index-7 pixels streaming
    reset = 1'b0;
    set_pix(1'b0, 8'h0, 8'd7, 1'b1, 1'b1, 10'd3);
    count_busy(n);
    chk("busy_clks", n, 256);
    set_pix(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 10'd0);

    // high byte alone uses the reset lo_hold
    host_wr(9'h011, 8'hAB);
    look(1'b0, 8'h0, 8'd8);
    chk4("hionly", 8'hBB, 8'h00, 8'h00, 4'hA);

    // writes issued during clear were dropped
    look(1'b0, 8'h0, 8'd3);
    chk4("clrwr", 0, 0, 0, 0);

    host_wr(9'h00E, 8'h5A);
    host_wr(9'h00F, 8'hC3);
    look(1'b0, 8'h0, 8'd7);
    chk4("idx7", 8'h33, 8'h55, 8'hAA, 4'hC);

    look(1'b1, 8'hF8, 8'h1F);
    chk4("rgb565", 8'hFF, 8'h00, 8'hFF, 4'hF);
    chk("rgb565_pe", 32'(bus.pixel_out_ena), 1);

    send_pix(1'b1, 8'hF8, 8'h1F, 1'b0, 1'b1, 10'd7);
    send_pix(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, 10'd0);
    clk1();
    chk4("noena", 0, 0, 0, 0);
    chk("noena_pe", 32'(bus.pixel_out_ena), 0);
    chk("noena_en", 32'(bus.enable_out), 1);
    chk("noena_x", 32'(bus.x_out), 7);

    // read-before-write collision on entry 9
    host_wr(9'h012, 8'h21);
    host_wr(9'h013, 8'h43);
    host_wr(9'h012, 8'h65);
    send_pix(1'b0, 8'h0, 8'd9, 1'b1, 1'b1, 10'd1);
    bus.pal_wr_addr = 9'h013;
    bus.pal_wr_data = 8'h87;
    bus.pal_wr_ena  = 1'b1;
    send_pix(1'b0, 8'h0, 8'd9, 1'b1, 1'b1, 10'd2);
    clk1();
    chk4("coll_old", 8'h33, 8'h22, 8'h11, 4'h4);
    send_pix(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 10'd0);
    clk1();
    chk4("coll_new", 8'h77, 8'h66, 8'h55, 4'h8);

    // x ramp
    for (int i = 0; i < 12; i++) begin
      send_pix(1'b0, 8'h0, 8'd7, 1'b1, 1'b1, 10'(100 + i));
      if (i == 5) chk("ramp_mid", 32'(bus.x_out), 103);
    end
    send_pix(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 10'd0);
    clk1();
    chk("ramp_end", 32'(bus.x_out), 111);

    // reset mid-frame, then reset mid-clear
    send_pix(1'b0, 8'h0, 8'd7, 1'b1, 1'b1, 10'd55);
    send_pix(1'b0, 8'h0, 8'd7, 1'b1, 1'b1, 10'd56);
    clk1();
    chk("pre_rst_x", 32'(bus.x_out), 55);
    reset = 1'b1;
    clk1();
    chk("mf_rst_x", 32'(bus.x_out), 0);
    chk("mf_rst_pe", 32'(bus.pixel_out_ena), 0);
    chk("mf_rst_busy", 32'(bus.pal_busy), 1);
    reset = 1'b0;
    set_pix(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 10'd0);
    repeat (100) clk1();
    chk("mc_busy", 32'(bus.pal_busy), 1);
    reset = 1'b1;
    clk1();
    clk1();
    reset = 1'b0;
    count_busy(n);
    chk("busy_clks2", n, 256);
    look(1'b0, 8'h0, 8'd7);
    chk4("recleared", 0, 0, 0, 0);

    armed = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
